// File: rtl/clk_div_ctrl_if.sv
// Ratio request channel for the run-time clock divider controller.
// The requester drives valid/ratio; the controller answers ready/ack/err.
interface clk_div_ctrl_if #(
    parameter int W = 4
);
    logic         cfg_valid;
    logic [W-1:0] cfg_ratio;
    logic         cfg_ready;
    logic         cfg_ack;
    logic         cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ratio,
        input  cfg_ready,
        input  cfg_ack,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ratio,
        output cfg_ready,
        output cfg_ack,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time integer clock divider controller.
// Ratio updates land only on output-period boundaries, so out_clk never glitches.
module clk_div_ctrl #(
    parameter int W           = 4,
    parameter int RESET_RATIO = 5
) (
    input  logic           in_clk,
    input  logic           reset,
    input  logic           enable,
    clk_div_ctrl_if.slave  cfg,
    output logic           out_clk,
    output logic           period_tick,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nx;

    logic [W-1:0] ratio;
    logic [W-1:0] ratio_nx;
    logic [W-1:0] pend_ratio;
    logic [W-1:0] pend_nx;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nx;
    logic [W:0]   half;

    logic         xfer;
    logic         legal;
    logic         wrap;
    logic         load_q;
    logic         load_nx;
    logic         ack_q;
    logic         ack_nx;
    logic         err_q;
    logic         err_nx;
    logic         tick_nx;
    logic         clk_nx;

    assign cfg.cfg_ready = (state != PEND);
    assign cfg.cfg_ack   = ack_q;
    assign cfg.cfg_err   = err_q;
    assign busy          = (state != IDLE);

    assign xfer  = cfg.cfg_valid && cfg.cfg_ready;
    assign legal = (cfg.cfg_ratio >= W'(2));
    assign wrap  = (state != IDLE) && (cnt == ratio - W'(1));
    assign half  = ({1'b0, ratio} + {{W{1'b0}}, 1'b1}) >> 1;

    always_ff @(posedge in_clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ratio       <= W'(RESET_RATIO);
            pend_ratio  <= '0;
            cnt         <= '0;
            load_q      <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            period_tick <= 1'b0;
            out_clk     <= 1'b0;
        end else begin
            state       <= state_nx;
            ratio       <= ratio_nx;
            pend_ratio  <= pend_nx;
            cnt         <= cnt_nx;
            load_q      <= load_nx;
            ack_q       <= ack_nx;
            err_q       <= err_nx;
            period_tick <= tick_nx;
            out_clk     <= clk_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (enable)
                    state_nx = RUN;
            end
            RUN: begin
                if (wrap && !enable)
                    state_nx = IDLE;
                else if (xfer && legal)
                    state_nx = PEND;
            end
            PEND: begin
                if (wrap)
                    state_nx = enable ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // out_clk trails cnt by one cycle, so a boundary reload is acked
    // one cycle late to line up with the first high cycle of the new period.
    always_comb begin
        ratio_nx = ratio;
        pend_nx  = pend_ratio;
        cnt_nx   = '0;
        load_nx  = 1'b0;
        ack_nx   = load_q;
        err_nx   = xfer && !legal;
        tick_nx  = wrap;
        clk_nx   = (state != IDLE) && ({1'b0, cnt} < half);
        if ((state != IDLE) && !wrap)
            cnt_nx = cnt + W'(1);
        unique case (state)
            IDLE: begin
                if (xfer && legal) begin
                    ratio_nx = cfg.cfg_ratio;
                    ack_nx   = 1'b1;
                end
            end
            RUN: begin
                if (xfer && legal) begin
                    if (wrap && !enable) begin
                        ratio_nx = cfg.cfg_ratio;
                        ack_nx   = 1'b1;
                    end else begin
                        pend_nx = cfg.cfg_ratio;
                    end
                end
            end
            PEND: begin
                if (wrap) begin
                    ratio_nx = pend_ratio;
                    if (enable)
                        load_nx = 1'b1;
                    else
                        ack_nx = 1'b1;
                end
            end
            default: begin
                ratio_nx = ratio;
            end
        endcase
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomised bench for clk_div_ctrl against a period-level reference model.
// Each scenario task drives stimulus and checks all outputs every cycle.
module tb_clk_div_ctrl;

    logic in_clk;
    logic reset;
    logic enable;
    logic out_clk;
    logic period_tick;
    logic busy;

    clk_div_ctrl_if #(.W(4)) cfg ();

    clk_div_ctrl #(
        .W(4),
        .RESET_RATIO(5)
    ) dut (
        .in_clk(in_clk),
        .reset(reset),
        .enable(enable),
        .cfg(cfg),
        .out_clk(out_clk),
        .period_tick(period_tick),
        .busy(busy)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Reference model: running flag, position in period, ratio, pending ratio
    bit m_run;
    int m_n;
    int m_pos;
    int m_pend;
    bit m_ackd;
    bit e_out, e_tick, e_ack, e_err, e_busy, e_ready;

    task automatic model_reset();
        m_run = 0; m_n = 5; m_pos = 0; m_pend = -1; m_ackd = 0;
    endtask

    task automatic model_step(input bit en, input bit v, input int r);
        bit rdy;
        bit acc;
        bit last;
        rdy    = (m_pend < 0);
        acc    = v && rdy && (r >= 2);
        last   = m_run && (m_pos == m_n - 1);
        e_out  = m_run && (m_pos < (m_n + 1) / 2);
        e_tick = last;
        e_err  = v && rdy && (r < 2);
        e_ack  = m_ackd;
        m_ackd = 0;
        if (!m_run) begin
            if (acc) begin m_n = r; e_ack = 1; end
            m_run = en;
            m_pos = 0;
        end else if (last) begin
            m_pos = 0;
            if (m_pend >= 0) begin
                m_n = m_pend; m_pend = -1;
                if (en) m_ackd = 1; else e_ack = 1;
            end else if (acc) begin
                if (en) m_pend = r;
                else begin m_n = r; e_ack = 1; end
            end
            m_run = en;
        end else begin
            m_pos++;
            if (acc) m_pend = r;
        end
        e_busy  = m_run;
        e_ready = (m_pend < 0);
    endtask

    function automatic logic [5:0] obs();
        return {out_clk, period_tick, cfg.cfg_ack, cfg.cfg_err, busy, cfg.cfg_ready};
    endfunction

    function automatic logic [5:0] expv();
        return {e_out, e_tick, e_ack, e_err, e_busy, e_ready};
    endfunction

    task automatic step(input bit en, input bit v, input int r);
        enable = en;
        cfg.cfg_valid = v;
        cfg.cfg_ratio = 4'(r);
        @(posedge in_clk);
        #1;
        model_step(en, v, r);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 0;
        enable = 0;
        cfg.cfg_valid = 0;
        cfg.cfg_ratio = '0;
        repeat (2) @(posedge in_clk);
        #1;
        model_reset();
        reset = 1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (obs() !== 6'b000001) begin
            bad++;
            $display("FAIL reset_state got=%b exp=%b", obs(), 6'b000001);
        end
    endtask

    task automatic test_default_run();
        int ticks;
        ticks = 0;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            step(1, 0, 0);
            ticks += int'(period_tick);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL default_run cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
        total++;
        if (ticks !== 4) begin
            bad++;
            $display("FAIL default_ticks got=%0d exp=%0d", ticks, 4);
        end
    endtask

    task automatic test_ratio_change();
        do_reset();
        for (int i = 0; i < 12 && !(m_run && m_pos == 1); i++)
            step(1, 0, 0);
        total++;
        if (!(m_run && m_pos == 1)) begin
            bad++;
            $display("FAIL ratio_change_sync got=%0d exp=%0d", m_pos, 1);
        end
        step(1, 1, 4);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL ratio_change cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
            step(1, 0, 0);
        end
    endtask

    task automatic test_illegal_idle();
        int vals[4] = '{1, 0, 7, 0};
        bit vld[4] = '{1, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, vld[i], vals[i]);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL illegal_idle cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL ratio7_run cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
    endtask

    task automatic test_stop();
        do_reset();
        step(0, 1, 6);
        for (int i = 0; i < 14 && !(m_run && m_pos == 2); i++)
            step(1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL stop cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL restart cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
    endtask

    task automatic test_boundary_req();
        int acks;
        acks = 0;
        do_reset();
        for (int i = 0; i < 12 && !(m_run && m_pos == 4); i++)
            step(1, 0, 0);
        step(1, 1, 3);
        acks += int'(cfg.cfg_ack);
        for (int i = 0; i < 15; i++) begin
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL boundary_req cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
            step(1, 0, 0);
            acks += int'(cfg.cfg_ack);
        end
        total++;
        if (acks !== 1) begin
            bad++;
            $display("FAIL boundary_ack_count got=%0d exp=%0d", acks, 1);
        end
    endtask

    task automatic test_reset_pend();
        int acks;
        acks = 0;
        do_reset();
        for (int i = 0; i < 12 && !(m_run && m_pos == 0); i++)
            step(1, 0, 0);
        step(1, 1, 4);
        total++;
        if (obs() !== expv() || out_clk !== 1'b1 || cfg.cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL pend_before_reset got=%b exp=%b", obs(), expv());
        end
        #1;
        reset = 0;
        #1;
        total++;
        if ({out_clk, busy, cfg.cfg_ready} !== 3'b001) begin
            bad++;
            $display("FAIL async_reset got=%b exp=%b", {out_clk, busy, cfg.cfg_ready}, 3'b001);
        end
        cfg.cfg_valid = 0;
        enable = 0;
        repeat (2) @(posedge in_clk);
        #1;
        model_reset();
        reset = 1;
        for (int i = 0; i < 15; i++) begin
            step(1, 0, 0);
            acks += int'(cfg.cfg_ack);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL after_reset cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
        total++;
        if (acks !== 0) begin
            bad++;
            $display("FAIL dropped_ack got=%0d exp=%0d", acks, 0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                 int'($urandom_range(0, 15)));
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
        end
    endtask

    initial begin
        reset = 0;
        enable = 0;
        cfg.cfg_valid = 0;
        cfg.cfg_ratio = '0;
        #2;
        test_reset();
        test_default_run();
        test_ratio_change();
        test_illegal_idle();
        test_stop();
        test_boundary_req();
        test_reset_pend();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
